// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared constants, state encoding and rectangle command types for the frame-buffer write scheduler
package fb_pkg;
    localparam int H_LEN   = 200;
    localparam int V_LEN   = 150;
    localparam int AW      = 15;
    localparam int CW      = 12;
    localparam int FB_SIZE = H_LEN * V_LEN;
    localparam int STARVE  = 8;
    localparam int SW      = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_e;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] w;
        logic [7:0] h;
    } rect_geom_t;

    typedef struct packed {
        rect_geom_t    geom;
        logic [CW-1:0] rgb;
    } rect_cmd_t;

    // A rectangle with no area or starting off-screen produces no writes at all.
    function automatic logic rect_is_degenerate(input rect_geom_t g);
        return (g.w == 8'd0) || (g.h == 8'd0) || (g.x >= 8'(H_LEN)) || (g.y >= 8'(V_LEN));
    endfunction
endpackage

// File: rtl/fb_rect_walker.sv
// rtl/fb_rect_walker.sv - clips a rectangle at load and walks it row-major with an incremental address
module fb_rect_walker
    import fb_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  rect_geom_t    geom_i,
    input  logic          advance_i,
    output logic [AW-1:0] addr_o,
    output logic          last_o
);
    localparam logic [AW-1:0] ROW_STEP = AW'(H_LEN);

    logic [7:0]    w_q, h_q, col_q, row_q;
    logic [7:0]    w_d, h_d, col_d, row_d;
    logic [AW-1:0] addr_q, addr_d, row_base_q, row_base_d;
    logic [7:0]    w_room, h_room, w_eff, h_eff;
    logic [AW-1:0] y_ext, start_addr;

    always_comb begin
        w_room     = 8'(H_LEN) - geom_i.x;
        h_room     = 8'(V_LEN) - geom_i.y;
        w_eff      = (geom_i.w < w_room) ? geom_i.w : w_room;
        h_eff      = (geom_i.h < h_room) ? geom_i.h : h_room;
        // y*200 as y*128 + y*64 + y*8
        y_ext      = {{(AW-8){1'b0}}, geom_i.y};
        start_addr = (y_ext << 7) + (y_ext << 6) + (y_ext << 3) + {{(AW-8){1'b0}}, geom_i.x};

        w_d        = w_q;
        h_d        = h_q;
        col_d      = col_q;
        row_d      = row_q;
        addr_d     = addr_q;
        row_base_d = row_base_q;
        if (load_i) begin
            w_d        = w_eff;
            h_d        = h_eff;
            col_d      = 8'd0;
            row_d      = 8'd0;
            addr_d     = start_addr;
            row_base_d = start_addr;
        end else if (advance_i) begin
            if (col_q == w_q - 8'd1) begin
                col_d      = 8'd0;
                row_d      = row_q + 8'd1;
                row_base_d = row_base_q + ROW_STEP;
                addr_d     = row_base_q + ROW_STEP;
            end else begin
                col_d  = col_q + 8'd1;
                addr_d = addr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_q        <= 8'd0;
            h_q        <= 8'd0;
            col_q      <= 8'd0;
            row_q      <= 8'd0;
            addr_q     <= '0;
            row_base_q <= '0;
        end else begin
            w_q        <= w_d;
            h_q        <= h_d;
            col_q      <= col_d;
            row_q      <= row_d;
            addr_q     <= addr_d;
            row_base_q <= row_base_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (col_q == w_q - 8'd1) && (row_q == h_q - 8'd1);
endmodule

// File: rtl/fb_write_sched.sv
// rtl/fb_write_sched.sv - shares the frame-buffer write port between single-pixel writes and a rectangle-fill engine
module fb_write_sched
    import fb_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          px_valid,
    output logic          px_ready,
    input  logic [AW-1:0] px_addr,
    input  logic [CW-1:0] px_rgb,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [7:0]    cmd_x,
    input  logic [7:0]    cmd_y,
    input  logic [7:0]    cmd_w,
    input  logic [7:0]    cmd_h,
    input  logic [CW-1:0] cmd_rgb,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] addr,
    output logic [CW-1:0] inrgb,
    output logic          we
);
    state_e        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          we_q, we_d, busy_q, busy_d, done_q, done_d, fill_end_q, fill_end_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [CW-1:0] rgb_q, rgb_d, fill_rgb_q, fill_rgb_d;
    rect_cmd_t     cmd;
    logic          fill_st, fill_issue, cmd_accept, cmd_degen, walk_last;
    logic [AW-1:0] walk_addr;

    fb_rect_walker u_walker (
        .clk       (clk),
        .rst       (rst),
        .load_i    (cmd_accept & ~cmd_degen),
        .geom_i    (cmd.geom),
        .advance_i (fill_issue),
        .addr_o    (walk_addr),
        .last_o    (walk_last)
    );

    always_comb begin
        cmd        = {cmd_x, cmd_y, cmd_w, cmd_h, cmd_rgb};
        fill_st    = (state_q == ST_FILL);
        px_ready   = px_valid & ~(fill_st & (starve_q == SW'(STARVE)));
        fill_issue = fill_st & ~px_ready;
        cmd_accept = cmd_valid & ~fill_st;
        cmd_degen  = rect_is_degenerate(cmd.geom);

        state_d    = state_q;
        starve_d   = starve_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        rgb_d      = rgb_q;
        fill_rgb_d = fill_rgb_q;
        busy_d     = fill_st;
        // fill completion is delayed one cycle so done follows the last write
        done_d     = fill_end_q | (cmd_accept & cmd_degen);
        fill_end_d = 1'b0;

        if (px_ready) begin
            if (px_addr < AW'(FB_SIZE)) begin
                we_d   = 1'b1;
                addr_d = px_addr;
                rgb_d  = px_rgb;
            end
        end else if (fill_issue) begin
            we_d   = 1'b1;
            addr_d = walk_addr;
            rgb_d  = fill_rgb_q;
        end

        if (fill_st) begin
            starve_d = px_ready ? starve_q + SW'(1) : '0;
            if (fill_issue && walk_last) begin
                state_d    = ST_IDLE;
                fill_end_d = 1'b1;
            end
        end else begin
            starve_d = '0;
            if (cmd_accept && !cmd_degen) begin
                state_d    = ST_FILL;
                fill_rgb_d = cmd.rgb;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            starve_q   <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            rgb_q      <= '0;
            fill_rgb_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fill_end_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            rgb_q      <= rgb_d;
            fill_rgb_q <= fill_rgb_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fill_end_q <= fill_end_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = busy_q;
    assign done      = done_q;
    assign addr      = addr_q;
    assign inrgb     = rgb_q;
    assign we        = we_q;
endmodule

// File: tb/tb_fb_write_sched.sv
// tb/tb_fb_write_sched.sv - self-checking bench for fb_write_sched with a queue-based reference model
module tb_fb_write_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic        px_valid, px_ready, cmd_valid, cmd_ready, busy, done, we;
    logic [14:0] px_addr, addr;
    logic [11:0] px_rgb, cmd_rgb, inrgb;
    logic [7:0]  cmd_x, cmd_y, cmd_w, cmd_h;

    always #5 clk = ~clk;

    fb_write_sched dut (
        .clk(clk), .rst(rst),
        .px_valid(px_valid), .px_ready(px_ready), .px_addr(px_addr), .px_rgb(px_rgb),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_rgb(cmd_rgb),
        .busy(busy), .done(done), .addr(addr), .inrgb(inrgb), .we(we)
    );

    int checks = 0;
    int errors = 0;

    // reference model: pending fill pixels as a list of addresses
    int          mq[$];
    logic [11:0] mf_rgb;
    int          m_starve;
    logic        m_we, m_busy, m_done, m_pend, m_pxr, m_cmdr;
    int          m_addr;
    logic [11:0] m_rgb;
    logic        s_pxr;

    typedef struct {
        logic pv; int pa; logic [11:0] pr;
        logic cv; int x; int y; int w; int h; logic [11:0] cr;
        logic e_pxr; logic e_we; int e_addr; logic [11:0] e_rgb; logic e_busy; logic e_done;
    } vec_t;
    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_starve = 0; m_we = 0; m_addr = 0; m_rgb = '0; mf_rgb = '0;
        m_busy = 0; m_done = 0; m_pend = 0;
    endtask

    task automatic model_step(input logic pv, input int pa, input logic [11:0] pr,
                              input logic cv, input int x, input int y, input int w, input int h,
                              input logic [11:0] cr);
        logic active, grant, nd;
        int   we_n, he_n;
        active = (mq.size() > 0);
        grant  = pv && !(active && m_starve == 8);
        m_pxr  = grant;
        m_cmdr = !active;
        nd     = m_pend;
        m_pend = 0;
        m_we   = 0;
        if (grant) begin
            if (pa < 30000) begin m_we = 1; m_addr = pa; m_rgb = pr; end
            if (active) m_starve++;
        end else if (active) begin
            m_we = 1; m_addr = mq.pop_front(); m_rgb = mf_rgb; m_starve = 0;
            if (mq.size() == 0) m_pend = 1;
        end
        if (!active) begin
            m_starve = 0;
            if (cv) begin
                if (w == 0 || h == 0 || x >= 200 || y >= 150) nd = 1;
                else begin
                    we_n = (w < 200 - x) ? w : 200 - x;
                    he_n = (h < 150 - y) ? h : 150 - y;
                    for (int r = 0; r < he_n; r++)
                        for (int c = 0; c < we_n; c++)
                            mq.push_back((y + r) * 200 + x + c);
                    mf_rgb = cr;
                end
            end
        end
        m_busy = active;
        m_done = nd;
    endtask

    task automatic step(input logic pv, input int pa, input logic [11:0] pr,
                        input logic cv, input int x, input int y, input int w, input int h,
                        input logic [11:0] cr);
        px_valid = pv; px_addr = 15'(pa); px_rgb = pr;
        cmd_valid = cv; cmd_x = 8'(x); cmd_y = 8'(y); cmd_w = 8'(w); cmd_h = 8'(h); cmd_rgb = cr;
        #1;
        model_step(pv, pa, pr, cv, x, y, w, h, cr);
        s_pxr = px_ready;
        chk("px_ready", px_ready, m_pxr);
        chk("cmd_ready", cmd_ready, m_cmdr);
        @(posedge clk); #1;
        chk("we", we, m_we);
        chk("addr", addr, m_addr);
        chk("inrgb", inrgb, m_rgb);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
    endtask

    task automatic idle();
        step(0, 0, 12'h0, 0, 0, 0, 0, 0, 12'h0);
    endtask

    task automatic do_reset();
        rst = 1; px_valid = 0; px_addr = '0; px_rgb = '0;
        cmd_valid = 0; cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_rgb = '0;
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        chk("rst_we", we, 0); chk("rst_addr", addr, 0); chk("rst_inrgb", inrgb, 0);
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        int wq[$];
        int fi[$];
        int nb, bw, nd, last_w, done_at, nw;

        tbl[0]  = '{1, 5,     12'h0F0, 1, 0,   0,   1,  1,  12'hABC, 1, 1, 5,     12'h0F0, 0, 0};
        tbl[1]  = '{0, 0,     12'h000, 0, 0,   0,   0,  0,  12'h000, 0, 1, 0,     12'hABC, 1, 0};
        tbl[2]  = '{0, 0,     12'h000, 0, 0,   0,   0,  0,  12'h000, 0, 0, 0,     12'hABC, 0, 1};
        tbl[3]  = '{0, 0,     12'h000, 1, 10,  10,  0,  5,  12'h123, 0, 0, 0,     12'hABC, 0, 1};
        tbl[4]  = '{0, 0,     12'h000, 0, 0,   0,   0,  0,  12'h000, 0, 0, 0,     12'hABC, 0, 0};
        tbl[5]  = '{0, 0,     12'h000, 1, 198, 149, 10, 10, 12'h055, 0, 0, 0,     12'hABC, 0, 0};
        tbl[6]  = '{0, 0,     12'h000, 0, 0,   0,   0,  0,  12'h000, 0, 1, 29998, 12'h055, 1, 0};
        tbl[7]  = '{0, 0,     12'h000, 0, 0,   0,   0,  0,  12'h000, 0, 1, 29999, 12'h055, 1, 0};
        tbl[8]  = '{0, 0,     12'h000, 0, 0,   0,   0,  0,  12'h000, 0, 0, 29999, 12'h055, 0, 1};
        tbl[9]  = '{0, 0,     12'h000, 0, 0,   0,   0,  0,  12'h000, 0, 0, 29999, 12'h055, 0, 0};
        tbl[10] = '{1, 30000, 12'hFFF, 0, 0,   0,   0,  0,  12'h000, 1, 0, 29999, 12'h055, 0, 0};
        tbl[11] = '{1, 29999, 12'h777, 0, 0,   0,   0,  0,  12'h000, 1, 1, 29999, 12'h777, 0, 0};
        tbl[12] = '{0, 0,     12'h000, 1, 200, 0,   5,  5,  12'h111, 0, 0, 29999, 12'h777, 0, 1};
        tbl[13] = '{0, 0,     12'h000, 1, 0,   150, 1,  1,  12'h222, 0, 0, 29999, 12'h777, 0, 1};
        tbl[14] = '{0, 0,     12'h000, 0, 0,   0,   0,  0,  12'h000, 0, 0, 29999, 12'h777, 0, 0};

        do_reset();
        for (int i = 0; i < 10; i++) idle();

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].pv, tbl[i].pa, tbl[i].pr, tbl[i].cv, tbl[i].x, tbl[i].y, tbl[i].w, tbl[i].h, tbl[i].cr);
            chk($sformatf("vec%0d_px_ready", i), s_pxr, tbl[i].e_pxr);
            chk($sformatf("vec%0d_we", i), we, tbl[i].e_we);
            chk($sformatf("vec%0d_addr", i), addr, tbl[i].e_addr);
            chk($sformatf("vec%0d_inrgb", i), inrgb, tbl[i].e_rgb);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("vec%0d_done", i), done, tbl[i].e_done);
        end

        // basic fill: 2,3,4,2
        step(0, 0, 12'h0, 1, 2, 3, 4, 2, 12'hF00);
        nb = 0; bw = 0; nd = 0; last_w = -1; done_at = -1;
        for (int i = 0; i < 14; i++) begin
            idle();
            if (we) begin wq.push_back(int'(addr)); last_w = i; end
            if (busy) nb++;
            if (busy !== we) bw++;
            if (done) begin nd++; done_at = i; end
        end
        chk("t2_nwrites", wq.size(), 8);
        for (int k = 0; k < wq.size() && k < 8; k++)
            chk("t2_addr", wq[k], (k < 4) ? 602 + k : 802 + (k - 4));
        chk("t2_busy_cycles", nb, 8);
        chk("t2_busy_align", bw, 0);
        chk("t2_done_count", nd, 1);
        chk("t2_done_at", done_at, last_w + 1);

        // starvation: pixel channel saturated during a 20-pixel fill
        step(1, 1000, 12'h00F, 1, 0, 0, 20, 1, 12'h0A0);
        nd = 0; nw = 0;
        for (int i = 0; i < 200; i++) begin
            step(1, 1001 + i, 12'h00F, 0, 0, 0, 0, 0, 12'h0);
            if (we && inrgb == 12'h0A0) fi.push_back(i);
            if (!we) nw++;
            if (done) nd++;
        end
        chk("t4_fill_count", fi.size(), 20);
        if (fi.size() > 0) chk("t4_first_fill", fi[0], 8);
        for (int k = 1; k < fi.size(); k++) chk("t4_fill_gap", fi[k] - fi[k-1], 9);
        chk("t4_no_idle_slot", nw, 0);
        chk("t4_done_count", nd, 1);
        idle();

        // reset mid-fill, then a fresh fill
        step(0, 0, 12'h0, 1, 0, 0, 50, 2, 12'h321);
        for (int i = 0; i < 10; i++) idle();
        do_reset();
        nw = 0; nd = 0;
        for (int i = 0; i < 6; i++) begin
            idle();
            if (we) nw++;
            if (done) nd++;
        end
        chk("t6_quiet_writes", nw, 0);
        chk("t6_quiet_done", nd, 0);
        wq.delete();
        step(0, 0, 12'h0, 1, 5, 0, 3, 1, 12'h456);
        for (int i = 0; i < 6; i++) begin
            idle();
            if (we) wq.push_back(int'(addr));
        end
        chk("t6_nwrites", wq.size(), 3);
        if (wq.size() > 0) chk("t6_first_addr", wq[0], 5);

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 1) == 1, $urandom_range(0, 30100), 12'($urandom),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 210), $urandom_range(0, 155),
                 $urandom_range(0, 40), $urandom_range(0, 3), 12'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
